// File: rtl/fetch_pc_unit_pkg.sv
// Shared types and constants for the instruction-fetch PC unit.
package fetch_pc_unit_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned IMEM_AW  = 12;
    localparam int unsigned PC_INC_C = 2;
    localparam int unsigned PC_INC_W = 4;

    typedef enum logic [0:0] {
        ST_BUBBLE = 1'b0,
        ST_RUN    = 1'b1
    } fetch_state_e;

    // Word-aligned form of a byte address.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

    // Halfword-aligned form of a byte address.
    function automatic logic [XLEN-1:0] half_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:1], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Control and instruction-memory address bus between the fetch PC unit and its neighbours.
interface fetch_pc_unit_if;
    import fetch_pc_unit_pkg::*;

    logic                stall;
    logic                buffer_stall;
    logic                redirect;
    logic [XLEN-1:0]     redirect_pc;
    logic                inst_is_c;
    logic                imem_en;
    logic [IMEM_AW-1:0]  imem_addr;
    logic [XLEN-1:0]     inst_pc;
    logic                inst_valid;
    logic                odd_start;

    modport master (
        input  stall, buffer_stall, redirect, redirect_pc, inst_is_c,
        output imem_en, imem_addr, inst_pc, inst_valid, odd_start
    );

    modport slave (
        output stall, buffer_stall, redirect, redirect_pc, inst_is_c,
        input  imem_en, imem_addr, inst_pc, inst_valid, odd_start
    );

endinterface

// File: rtl/fetch_pc_unit.sv
// Fetch-address generator: issues word fetches to a 1-cycle synchronous memory
// and tracks the byte PC of the instruction presented to decode.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          nrst,
    fetch_pc_unit_if.master bus
);

    fetch_state_e    state, state_nxt;
    logic [XLEN-1:0] fetch_pc, fetch_pc_nxt;
    logic [XLEN-1:0] inst_pc, inst_pc_nxt;
    logic            pending_odd, pending_odd_nxt;

    // Bit 0 of the redirect target is meaningless for halfword-aligned code.
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = bus.redirect_pc[0];

    // State register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= ST_BUBBLE;
        else       state <= state_nxt;
    end

    // PC registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            fetch_pc    <= word_align(RESET_PC);
            inst_pc     <= half_align(RESET_PC);
            pending_odd <= 1'b0;
        end else begin
            fetch_pc    <= fetch_pc_nxt;
            inst_pc     <= inst_pc_nxt;
            pending_odd <= pending_odd_nxt;
        end
    end

    // Next state and next PC values; a redirect overrides every hold or advance.
    always_comb begin
        state_nxt       = state;
        fetch_pc_nxt    = fetch_pc;
        inst_pc_nxt     = inst_pc;
        pending_odd_nxt = pending_odd;
        if (bus.redirect) begin
            state_nxt       = ST_BUBBLE;
            fetch_pc_nxt    = word_align(bus.redirect_pc);
            inst_pc_nxt     = half_align(bus.redirect_pc);
            pending_odd_nxt = bus.redirect_pc[1];
        end else begin
            case (state)
                ST_BUBBLE: begin
                    state_nxt    = ST_RUN;
                    fetch_pc_nxt = fetch_pc + XLEN'(PC_INC_W);
                end
                ST_RUN: begin
                    if (!bus.stall && !bus.buffer_stall) begin
                        fetch_pc_nxt = fetch_pc + XLEN'(PC_INC_W);
                    end
                    if (!bus.stall) begin
                        inst_pc_nxt     = inst_pc + (bus.inst_is_c ? XLEN'(PC_INC_C)
                                                                   : XLEN'(PC_INC_W));
                        pending_odd_nxt = 1'b0;
                    end
                end
                default: state_nxt = ST_BUBBLE;
            endcase
        end
    end

    // Outputs: memory request and decode-side status.
    always_comb begin
        bus.imem_en    = 1'b0;
        bus.imem_addr  = fetch_pc[IMEM_AW+1:2];
        bus.inst_pc    = inst_pc;
        bus.inst_valid = (state == ST_RUN);
        bus.odd_start  = pending_odd && (state == ST_RUN);
        if (!bus.redirect) begin
            case (state)
                ST_BUBBLE: bus.imem_en = 1'b1;
                ST_RUN:    bus.imem_en = !bus.stall && !bus.buffer_stall;
                default:   bus.imem_en = 1'b0;
            endcase
        end
    end

endmodule
